// File: rtl/mem_stage.sv
// mem_stage: RV32I load/store stage with req/ack data-memory port, ack timeout and registered writeback.
// Define MEM_MISALIGN_TRAP_EN to retire misaligned halfword/word accesses with an error instead of issuing them.
module mem_stage #(
  parameter int ADDR_WIDTH  = 10,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [31:0]           instr_i,
  input  logic [31:0]           alu_result_i,
  input  logic [31:0]           rs2_data_i,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  wb_valid_o,
  output logic                  wb_we_o,
  output logic [4:0]            wb_rd_o,
  output logic [31:0]           wb_data_o,
  output logic                  err_o
);
  localparam int CW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_n;
  logic [6:0] op;
  logic [2:0] f3, r_f3;
  logic [1:0] off, r_off;
  logic [4:0] rd, r_rd;
  logic is_load, is_store, is_pass, bad_f3, misal, fault, start, timeout_hit, done;
  logic [3:0] be;
  logic [31:0] wdata, ld_data;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [CW-1:0] cnt;
  logic unused;
  assign unused = ^instr_i[31:15];
  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign rd = instr_i[11:7];
  assign off = alu_result_i[1:0];
  assign is_load = op == 7'b0000011;
  assign is_store = op == 7'b0100011;
  assign is_pass = op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  assign bad_f3 = is_load ? (f3 == 3'b011 || f3[2:1] == 2'b11) : is_store && f3 >= 3'b011;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = (is_load || is_store) && (f3[1] ? off != 2'b00 : f3[0] && off[0]);
`else
  assign misal = 1'b0;
`endif
  assign fault = bad_f3 || misal;
  assign start = valid_i && (is_load || is_store) && !fault;
  // an ack arriving in the final timeout cycle still completes the access
  assign timeout_hit = ACK_TIMEOUT != 0 && cnt == LAST && !mem_ack_i;
  assign done = mem_ack_i || timeout_hit;
  assign be = !is_store || f3[1] ? 4'hF : f3[0] ? 4'b0011 << {off[1], 1'b0} : 4'b0001 << off;
  assign wdata = f3[1] ? rs2_data_i : f3[0] ? {2{rs2_data_i[15:0]}} : {4{rs2_data_i[7:0]}};
  assign lb = mem_rdata_i[{r_off, 3'b000} +: 8];
  assign lh = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  assign ld_data = r_f3[1] ? mem_rdata_i :
                   r_f3[0] ? {{16{lh[15] & ~r_f3[2]}}, lh} : {{24{lb[7] & ~r_f3[2]}}, lb};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == S_IDLE ? (start ? S_WAIT : S_IDLE) : (done ? S_IDLE : S_WAIT);
  always_comb
    stall_o = rst_n && (state == S_IDLE ? start : !done);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_be_o <= '0;
      mem_wdata_o <= '0;
      r_f3 <= '0;
      r_off <= '0;
      r_rd <= '0;
      cnt <= '0;
      wb_valid_o <= 1'b0;
      wb_we_o <= 1'b0;
      wb_rd_o <= '0;
      wb_data_o <= '0;
      err_o <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      wb_we_o <= 1'b0;
      err_o <= 1'b0;
      if (state == S_IDLE) begin
        cnt <= '0;
        if (start) begin
          mem_req_o <= 1'b1;
          mem_we_o <= is_store;
          mem_addr_o <= {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
          mem_be_o <= be;
          mem_wdata_o <= wdata;
          r_f3 <= f3;
          r_off <= off;
          r_rd <= rd;
        end else if (valid_i) begin
          wb_valid_o <= 1'b1;
          wb_we_o <= is_pass && rd != 5'd0;
          wb_rd_o <= rd;
          wb_data_o <= alu_result_i;
          err_o <= fault;
        end
      end else if (done) begin
        mem_req_o <= 1'b0;
        wb_valid_o <= 1'b1;
        wb_we_o <= mem_ack_i && !mem_we_o && r_rd != 5'd0;
        wb_rd_o <= r_rd;
        wb_data_o <= mem_we_o ? mem_wdata_o : ld_data;
        err_o <= !mem_ack_i;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, random ops against a rule-level model, and hand sequences for reset, timeout and streaming.
module tb_mem_stage;
  logic clk = 0, rst_n = 0, valid_i = 0, mem_ack_i = 0;
  logic [31:0] instr_i = 0, alu_result_i = 0, rs2_data_i = 0, mem_rdata_i = 0;
  logic stall_o, mem_req_o, mem_we_o, wb_valid_o, wb_we_o, err_o;
  logic [9:0] mem_addr_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_wdata_o, wb_data_o;
  logic [4:0] wb_rd_o;
  int tests = 0, failed = 0;

  typedef struct {
    logic acc, st, we, err;
    logic [31:0] data;
    logic [9:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
  } exp_t;
  typedef struct {
    logic [31:0] ins, alu, rs2, rdata;
    int dly;
    exp_t e;
  } rec_t;
  rec_t tbl[$];

  mem_stage #(.ADDR_WIDTH(10), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i), .alu_result_i(alu_result_i),
    .rs2_data_i(rs2_data_i), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, alu, rs2, rdata);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic ld, st, ps, ill, mis;
    int bytes, lane;
    logic [63:0] v, mask;
    op = ins[6:0];
    f3 = ins[14:12];
    ld = op == 7'h03;
    st = op == 7'h23;
    ps = op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67};
    ill = ld ? (f3 inside {3'd3, 3'd6, 3'd7}) : (st && f3 >= 3'd3);
    bytes = 1 << f3[1:0];
    lane = (int'(alu[1:0]) / bytes) * bytes;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (ld || st) && (int'(alu[1:0]) % bytes != 0);
`else
    mis = 1'b0;
`endif
    e.acc = (ld || st) && !ill && !mis;
    e.st = st;
    e.err = (ld || st) && !e.acc;
    e.addr = alu[9:0] & 10'h3FC;
    e.be = ld ? 4'hF : 4'(((1 << bytes) - 1) << lane);
    e.wdata = bytes == 1 ? 32'(rs2[7:0]) * 32'h0101_0101 :
              bytes == 2 ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
    mask = (64'd1 << (8 * bytes)) - 64'd1;
    v = (64'(rdata) >> (8 * lane)) & mask;
    if (!f3[2] && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
    e.data = ld ? v[31:0] : alu;
    e.we = (ps || (ld && e.acc)) && ins[11:7] != 5'd0;
    return e;
  endfunction

  function automatic rec_t vec(input logic [31:0] ins, alu, rs2, rdata, input int dly,
                               input logic acc, st, we, err, input logic [31:0] data,
                               input logic [9:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    rec_t r;
    r.ins = ins; r.alu = alu; r.rs2 = rs2; r.rdata = rdata; r.dly = dly;
    r.e.acc = acc; r.e.st = st; r.e.we = we; r.e.err = err; r.e.data = data;
    r.e.addr = addr; r.e.be = be; r.e.wdata = wdata;
    return r;
  endfunction

  task automatic do_op(input string nm, input logic [31:0] ins, alu, rs2, rdata, input int dly, input exp_t e);
    @(negedge clk);
    instr_i = ins; alu_result_i = alu; rs2_data_i = rs2; valid_i = 1;
    #1;
    chk({nm, ".stall0"}, 32'(stall_o), 32'(e.acc));
    if (e.acc) begin
      for (int c = 1; c <= dly; c++) begin
        @(negedge clk);
        if (c == dly) begin mem_ack_i = 1; mem_rdata_i = rdata; end
        #1;
        if (c == 1) begin
          chk({nm, ".req"}, 32'(mem_req_o), 1);
          chk({nm, ".we"}, 32'(mem_we_o), 32'(e.st));
          chk({nm, ".addr"}, 32'(mem_addr_o), 32'(e.addr));
          if (e.st) begin
            chk({nm, ".be"}, 32'(mem_be_o), 32'(e.be));
            chk({nm, ".wdata"}, mem_wdata_o, e.wdata);
          end else chk({nm, ".be"}, 32'(mem_be_o), 32'hF);
        end
        chk({nm, ".stall"}, 32'(stall_o), 32'(c != dly));
      end
    end
    @(negedge clk);
    valid_i = 0; mem_ack_i = 0; mem_rdata_i = $urandom;
    #1;
    chk({nm, ".wb_valid"}, 32'(wb_valid_o), 1);
    chk({nm, ".wb_rd"}, 32'(wb_rd_o), 32'(ins[11:7]));
    chk({nm, ".wb_we"}, 32'(wb_we_o), 32'(e.we));
    chk({nm, ".err"}, 32'(err_o), 32'(e.err));
    chk({nm, ".req_low"}, 32'(mem_req_o), 0);
    if (e.we) chk({nm, ".wb_data"}, wb_data_o, e.data);
  endtask

  initial begin
    logic [6:0] ops[10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73};
    int nreq, nwb;
    tbl.push_back(vec(32'h0000_0283, 32'h003, 0, 32'h80FF_1234, 2, 1, 0, 1, 0, 32'hFFFF_FF80, 10'h000, 4'hF, 0));
    tbl.push_back(vec(32'h0000_4283, 32'h003, 0, 32'h80FF_1234, 1, 1, 0, 1, 0, 32'h0000_0080, 10'h000, 4'hF, 0));
    tbl.push_back(vec(32'h0000_1023, 32'h006, 32'hDEAD_BEEF, 0, 3, 1, 1, 0, 0, 0, 10'h004, 4'hC, 32'hBEEF_BEEF));
`ifdef MEM_MISALIGN_TRAP_EN
    tbl.push_back(vec(32'h0000_2103, 32'h002, 0, 32'h1234_5678, 1, 0, 0, 0, 1, 0, 10'h000, 4'hF, 0));
    tbl.push_back(vec(32'h0000_1483, 32'h101, 0, 32'hAAAA_1234, 1, 0, 0, 0, 1, 0, 10'h100, 4'hF, 0));
`else
    tbl.push_back(vec(32'h0000_2103, 32'h002, 0, 32'h1234_5678, 1, 1, 0, 1, 0, 32'h1234_5678, 10'h000, 4'hF, 0));
    tbl.push_back(vec(32'h0000_1483, 32'h101, 0, 32'hAAAA_1234, 1, 1, 0, 1, 0, 32'h0000_1234, 10'h100, 4'hF, 0));
`endif
    tbl.push_back(vec(32'h0000_1383, 32'h002, 0, 32'h80FF_1234, 1, 1, 0, 1, 0, 32'hFFFF_80FF, 10'h000, 4'hF, 0));
    tbl.push_back(vec(32'h0000_5383, 32'h002, 0, 32'h80FF_1234, 2, 1, 0, 1, 0, 32'h0000_80FF, 10'h000, 4'hF, 0));
    tbl.push_back(vec(32'h0000_0023, 32'h001, 32'h1234_56A5, 0, 2, 1, 1, 0, 0, 0, 10'h000, 4'h2, 32'hA5A5_A5A5));
    tbl.push_back(vec(32'h0000_2023, 32'h3F8, 32'h0123_4567, 0, 4, 1, 1, 0, 0, 0, 10'h3F8, 4'hF, 32'h0123_4567));
    tbl.push_back(vec(32'h0000_3283, 32'h010, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(vec(32'h0000_4023, 32'h010, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(vec(32'h0000_00B3, 32'h011, 0, 0, 1, 0, 0, 1, 0, 32'h11, 0, 0, 0));
    tbl.push_back(vec(32'h0000_0033, 32'h005, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(32'h0000_018F, 32'h005, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(32'h1234_5FB7, 32'h1234_5000, 0, 0, 1, 0, 0, 1, 0, 32'h1234_5000, 0, 0, 0));
    tbl.push_back(vec(32'h0000_0003, 32'h000, 0, 32'h0000_00FF, 3, 1, 0, 0, 0, 0, 10'h000, 4'hF, 0));

    #1;
    chk("rst.req", 32'(mem_req_o), 0);
    chk("rst.stall", 32'(stall_o), 0);
    chk("rst.wb_valid", 32'(wb_valid_o), 0);
    chk("rst.wb_data", wb_data_o, 0);
    chk("rst.err", 32'(err_o), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    foreach (tbl[i]) do_op($sformatf("vec%0d", i), tbl[i].ins, tbl[i].alu, tbl[i].rs2, tbl[i].rdata, tbl[i].dly, tbl[i].e);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] ins, alu, rs2, rd;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      alu = $urandom; rs2 = $urandom; rd = $urandom;
      do_op($sformatf("rnd%0d", i), ins, alu, rs2, rd, $urandom_range(1, 4), model(ins, alu, rs2, rd));
    end

    // ack never arrives: request drops after four cycles and the op retires with error
    @(negedge clk);
    instr_i = 32'h0000_2103; alu_result_i = 32'h040; valid_i = 1;
    nreq = 0; nwb = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 5) valid_i = 0;
      #1;
      if (mem_req_o) nreq++;
      if (c == 3) chk("to.stall_held", 32'(stall_o), 1);
      if (c == 4) chk("to.stall_release", 32'(stall_o), 0);
      if (c == 5) chk("to.wb_valid", 32'(wb_valid_o), 1);
      if (wb_valid_o) begin
        nwb++;
        chk("to.err", 32'(err_o), 1);
        chk("to.wb_we", 32'(wb_we_o), 0);
      end
    end
    chk("to.req_cycles", 32'(nreq), 4);
    chk("to.wb_count", 32'(nwb), 1);

    // ADD x1, LW x2, ADD x0 streamed with a single bubble around the load
    @(negedge clk);
    instr_i = 32'h0000_00B3; alu_result_i = 32'h11; valid_i = 1;
    #1 chk("st.stall0", 32'(stall_o), 0);
    @(negedge clk);
    instr_i = 32'h0000_2103; alu_result_i = 32'h010;
    #1;
    chk("st.stall1", 32'(stall_o), 1);
    chk("st.add_valid", 32'(wb_valid_o), 1);
    chk("st.add_rd", 32'(wb_rd_o), 1);
    chk("st.add_we", 32'(wb_we_o), 1);
    chk("st.add_data", wb_data_o, 32'h11);
    @(negedge clk);
    mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    chk("st.stall2", 32'(stall_o), 0);
    chk("st.req2", 32'(mem_req_o), 1);
    chk("st.bubble", 32'(wb_valid_o), 0);
    @(negedge clk);
    mem_ack_i = 0; instr_i = 32'h0000_0033; alu_result_i = 32'h77;
    #1;
    chk("st.stall3", 32'(stall_o), 0);
    chk("st.req3", 32'(mem_req_o), 0);
    chk("st.lw_valid", 32'(wb_valid_o), 1);
    chk("st.lw_rd", 32'(wb_rd_o), 2);
    chk("st.lw_we", 32'(wb_we_o), 1);
    chk("st.lw_data", wb_data_o, 32'hCAFE_F00D);
    @(negedge clk);
    valid_i = 0;
    #1;
    chk("st.x0_valid", 32'(wb_valid_o), 1);
    chk("st.x0_rd", 32'(wb_rd_o), 0);
    chk("st.x0_we", 32'(wb_we_o), 0);
    @(negedge clk);
    #1;
    chk("st.idle_valid", 32'(wb_valid_o), 0);
    chk("st.idle_err", 32'(err_o), 0);
    chk("st.hold_data", wb_data_o, 32'h77);

    // reset while waiting on ack; a late ack must not retire anything
    @(negedge clk);
    instr_i = 32'h0000_2103; alu_result_i = 32'h020; valid_i = 1;
    @(negedge clk);
    #1 chk("rw.req_before", 32'(mem_req_o), 1);
    rst_n = 0;
    #1;
    chk("rw.req", 32'(mem_req_o), 0);
    chk("rw.stall", 32'(stall_o), 0);
    chk("rw.wb_valid", 32'(wb_valid_o), 0);
    chk("rw.wb_we", 32'(wb_we_o), 0);
    chk("rw.wb_rd", 32'(wb_rd_o), 0);
    @(negedge clk);
    valid_i = 0; rst_n = 1;
    @(negedge clk);
    mem_ack_i = 1;
    @(negedge clk);
    mem_ack_i = 0;
    #1;
    chk("rw.late_ack_wb", 32'(wb_valid_o), 0);
    chk("rw.late_ack_req", 32'(mem_req_o), 0);
    @(negedge clk);
    #1 chk("rw.late_ack_wb2", 32'(wb_valid_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised RV32I memory-access pipeline stage between execute and writeback. Performs byte/halfword/word loads and stores over a request/acknowledge data-memory port with sign/zero extension and byte enables. Stalls the upstream pipeline while an access is outstanding and aborts hung accesses with a timeout. Delivers a registered writeback packet (rd, data, write enable, error) to the register file.

## Interface
- ADDR_WIDTH, 10: byte-address bits driven to data memory (≥3)
- ACK_TIMEOUT, 16: WAIT cycles without ack before abort; 0 disables timeout
- clk  input  1  clock, all flops rising edge
- rst_n  input  1  reset, asynchronous, active-low
- valid_i  input  1  instr_i/alu_result_i/rs2_data_i valid this cycle
- instr_i  input  32  RV32I instruction from execute
- alu_result_i  input  32  effective byte address (load/store) or result/link value (others)
- rs2_data_i  input  32  store data
- stall_o  output  1  upstream must hold inputs stable while high
- mem_req_o  output  1  access request, held until ack or abort
- mem_we_o  output  1  1 = store, 0 = load
- mem_addr_o  output  ADDR_WIDTH  word-aligned address, {alu_result_i[ADDR_WIDTH-1:2], 2'b00}
- mem_be_o  output  4  byte enables (stores; 4'b1111 on loads)
- mem_wdata_o  output  32  lane-replicated store data
- mem_ack_i  input  1  access complete; mem_rdata_i valid same cycle
- mem_rdata_i  input  32  read word
- wb_valid_o  output  1  writeback packet valid (one-cycle pulse per instruction)
- wb_we_o  output  1  write register file
- wb_rd_o  output  5  destination register, instr_i[11:7]
- wb_data_o  output  32  writeback data
- err_o  output  1  instruction retired with error (illegal funct3, timeout, misalign)

## Operation
- Decode instr_i[6:0]: 0000011 load, 0100011 store; 0110011, 0010011, 0110111, 0010111, 1101111, 1100111 "pass" (wb_data_o = alu_result_i); all others retire with wb_we_o=0.
- wb_we_o forced 0 when rd = 0, for stores, and on any error.
- FSM IDLE/WAIT. IDLE + valid load/store: stall_o=1 combinationally, register request (mem_req_o/we/addr/be/wdata), go WAIT. WAIT: stall_o = !mem_ack_i && !timeout_hit; on ack capture data, retire, go IDLE. mem_ack_i ignored in IDLE.
- Loads, off = addr[1:0]: LB/LBU lane off, sign/zero extend; LH/LHU lane off[1], sign/zero extend; LW full word. Load funct3 011/110/111 and store funct3 ≥011: no access, retire with err_o=1.
- Stores: SB be = 4'b0001<<off, wdata = {4{rs2[7:0]}}; SH be = 4'b0011<<(2*off[1]), wdata = {2{rs2[15:0]}}; SW be = 4'b1111, wdata = rs2.
- Timeout: counter cleared on entering WAIT, +1 per WAIT cycle without ack; count = ACK_TIMEOUT-1 with no ack → drop mem_req_o next edge, retire with err_o=1, go IDLE. Ack in the same cycle wins over timeout.
- Cycles with nothing retiring: wb_valid_o=0, wb_we_o=0, err_o=0; wb_rd_o/wb_data_o hold.

## Timing
- Reset: all outputs 0, state IDLE, counter 0. Reset in WAIT drops mem_req_o immediately; later ack ignored.
- Pass/illegal/misalign: retire next edge, no stall, throughput 1/cycle.
- Load/store: op at cycle 0 (stall), mem_req_o from cycle 1; ack in cycle N ≥ 1 → stall_o low in cycle N, wb_valid_o in cycle N+1. Minimum one bubble.
- Back-to-back memory ops: next op seen in IDLE the cycle after ack; mem_req_o low at least one cycle between accesses.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with off[0]=1, or LW/SW with off≠0 → no request, no stall, retire next edge with err_o=1, wb_we_o=0.
- Undefined: misaligned bits ignored (halfword uses off[1], word uses aligned word); err_o never set for alignment.

## Test plan
- Reset mid-WAIT: assert rst_n=0 with mem_req_o=1 → mem_req_o, stall_o, wb_* all 0 immediately; ack after reset → no wb_valid_o.
- LB x5, addr 0x003, rdata 0x80FF_1234 → be 4'b1111, wb_data_o 0xFFFF_FF80, wb_rd_o 5, wb_we_o 1; LBU same → 0x0000_0080.
- SH addr 0x006, rs2 0xDEAD_BEEF, ack after 3 cycles → mem_addr_o 0x004, be 4'b1100, wdata 0xBEEF_BEEF, stall_o high 3 cycles, wb_we_o 0.
- ACK_TIMEOUT=4, LW, no ack → mem_req_o high 4 cycles then 0, wb_valid_o=1 with err_o=1, wb_we_o=0, stall_o released.
- Streams ADD x1 (0x11), LW x2 (ack 1 cycle later), ADD x0 → wb pulses in order, x0 with wb_we_o 0, exactly one bubble around LW.
- LW addr 0x002: with MEM_MISALIGN_TRAP_EN err_o=1, mem_req_o never high; without, mem_addr_o 0x000, full word returned.
